serializer_sched: RTL

- Shares the single 13-bit `data_serializer` (16-bit sign-extended SPI-style shift-out) between two sample sources, ch0 and ch1, for example the I and Q ADC paths.
- Each channel has a one-deep holding register.
- Grants are round-robin.
- The block issues one `data_strobe` per word and spaces strobes so that no word is loaded while the serializer is still shifting.
- A sync header word is inserted at the start of every frame of FRAME_LEN data words.

---
 rtl/serializer_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/serializer_sched.sv
// serializer_sched: round-robin scheduler sharing one 13-bit word serializer between
// two sample channels, with strobe spacing and a sync header word per frame.
module serializer_sched #(
    parameter int          N_BITS    = 16,
    parameter int          GAP       = 2,
    parameter int          FRAME_LEN = 8,
    parameter logic [12:0] SYNC_WORD = 13'h0A5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [12:0] ch0_data,
    input  logic        ch0_valid,
    input  logic [12:0] ch1_data,
    input  logic        ch1_valid,
    input  logic        ovf_clr,
    output logic [12:0] ser_data,
    output logic        ser_strobe,
    output logic [1:0]  ser_src,
    output logic        frame_start,
    output logic        busy,
    output logic [1:0]  ovf
);
    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;

    localparam logic [5:0] WAIT_LOAD = 6'(N_BITS + GAP - 1);
    localparam logic [7:0] LAST_WORD = 8'(FRAME_LEN - 1);
    localparam logic [1:0] SRC_SYNC  = 2'd2;

    // chX_valid is a one-cycle qualifier with no back-pressure: in the cycle it is
    // offered, a sample is either captured into the holding register or dropped as overflow.
    logic [1:0]  ch_valid;
    logic [12:0] ch_data [2];

    assign ch_valid   = {ch1_valid, ch0_valid};
    assign ch_data[0] = ch0_data;
    assign ch_data[1] = ch1_data;

    state_t      state_q, state_d;
    logic [1:0]  pend_q, pend_d;
    logic [12:0] hold_q [2];
    logic [12:0] hold_d [2];
    logic [1:0]  ovf_q, ovf_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic        sync_done_q, sync_done_d;
    logic        last_grant_q, last_grant_d;
    logic [5:0]  wait_q, wait_d;
    logic [12:0] ser_data_q, ser_data_d;
    logic        ser_strobe_q, ser_strobe_d;
    logic [1:0]  ser_src_q, ser_src_d;
    logic        frame_start_q, frame_start_d;
    logic [1:0]  grant;

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        hold_d        = hold_q;
        ovf_d         = ovf_clr ? 2'b00 : ovf_q;
        word_cnt_d    = word_cnt_q;
        sync_done_d   = sync_done_q;
        last_grant_d  = last_grant_q;
        wait_d        = wait_q;
        ser_data_d    = ser_data_q;
        ser_strobe_d  = ser_strobe_q;
        ser_src_d     = ser_src_q;
        frame_start_d = frame_start_q;
        grant         = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (en && (pend_q != 2'b00)) begin
                    ser_strobe_d = 1'b1;
                    state_d      = S_STROBE;
                    if ((word_cnt_q == 8'd0) && !sync_done_q) begin
                        ser_data_d    = SYNC_WORD;
                        ser_src_d     = SRC_SYNC;
                        frame_start_d = 1'b1;
                        sync_done_d   = 1'b1;
                    end else begin
                        // On a tie the channel that was not served last wins.
                        if (pend_q[0] && (!pend_q[1] || last_grant_q)) begin
                            grant = 2'b01;
                        end else begin
                            grant = 2'b10;
                        end
                        ser_data_d   = grant[0] ? hold_q[0] : hold_q[1];
                        ser_src_d    = grant[0] ? 2'd0 : 2'd1;
                        last_grant_d = grant[1];
                        pend_d       = pend_q & ~grant;
                    end
                end
            end
            S_STROBE: begin
                ser_strobe_d  = 1'b0;
                frame_start_d = 1'b0;
                wait_d        = WAIT_LOAD;
                state_d       = S_WAIT;
                if (ser_src_q != SRC_SYNC) begin
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d  = 8'd0;
                        sync_done_d = 1'b0;
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 6'd0) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A granted channel has already had its pending bit cleared above, so a
        // sample arriving with its own grant is captured instead of overflowing.
        for (int c = 0; c < 2; c++) begin
            if (ch_valid[c]) begin
                if (!pend_d[c]) begin
                    hold_d[c] = ch_data[c];
                    pend_d[c] = 1'b1;
                end else begin
                    ovf_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pend_q        <= 2'b00;
            hold_q        <= '{default: '0};
            ovf_q         <= 2'b00;
            word_cnt_q    <= 8'd0;
            sync_done_q   <= 1'b0;
            last_grant_q  <= 1'b1;
            wait_q        <= 6'd0;
            ser_data_q    <= 13'd0;
            ser_strobe_q  <= 1'b0;
            ser_src_q     <= 2'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            hold_q        <= hold_d;
            ovf_q         <= ovf_d;
            word_cnt_q    <= word_cnt_d;
            sync_done_q   <= sync_done_d;
            last_grant_q  <= last_grant_d;
            wait_q        <= wait_d;
            ser_data_q    <= ser_data_d;
            ser_strobe_q  <= ser_strobe_d;
            ser_src_q     <= ser_src_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ser_data    = ser_data_q;
    assign ser_strobe  = ser_strobe_q;
    assign ser_src     = ser_src_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != S_IDLE);
    assign ovf         = ovf_q;

endmodule
